// File: rtl/intr_sched_pkg.sv
// Shared types, constants and the source-select helper for the interrupt scheduler.
package intr_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ASSERT = 2'd2
    } state_e;

    // Bit positions of the irq lines towards the core
    localparam int IRQ_EXT = 0;
    localparam int IRQ_TMR = 1;
    localparam int IRQ_SW  = 2;

    // Galois feedback polynomial, applied when the bit shifted out is 1
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Start at rnd mod 3 and rotate upward to the first enabled source.
    // An empty mask yields no source at all.
    function automatic logic [2:0] sel_src(input logic [1:0] rnd, input logic [2:0] mask);
        logic [1:0] idx;
        logic [2:0] res;
        res = 3'b000;
        idx = (rnd == 2'd3) ? 2'd0 : rnd;
        for (int k = 0; k < 3; k++) begin
            if (res == 3'b000 && mask[idx]) begin
                res[idx] = 1'b1;
            end
            idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/intr_sched_lfsr32.sv
// 32-bit right-shifting Galois LFSR; the all-zero lock-up seed is replaced by 1.
module lfsr32
    import intr_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] seed,
    input  logic        en,
    output logic [31:0] q
);

    logic [31:0] q_d;
    logic [31:0] q_q;
    logic [31:0] seed_safe;

    // seed is expected to be tied to a constant, so the reset value is static
    assign seed_safe = (seed == 32'h0) ? 32'h1 : seed;

    // Next state: shift right, fold taps back in when a 1 falls out
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = {1'b0, q_q[31:1]} ^ (q_q[0] ? LFSR_TAPS : 32'h0);
        end
    end

    // State register
    // NOTE: flops are written with <= so every register samples pre-edge values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= seed_safe;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/intr_sched.sv
// Interrupt scheduler: waits a pseudo-random interval, raises one irq line,
// holds it until acked, then either chains another irq or goes quiet.
module intr_sched
    import intr_sched_pkg::*;
#(
    parameter logic [31:0] SEED     = 32'h1,
    parameter int unsigned MIN_WAIT = 10,
    parameter int unsigned CNT_W    = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        intr_en_i,
    input  logic [3:0]  cfg_intvl_i,
    input  logic [2:0]  src_mask_i,
    input  logic [2:0]  intr_ack_i,
    output logic [2:0]  irq_o,
    output logic        busy_o,
    output logic [31:0] irq_cnt_o
);

    state_e             state_d,   state_q;
    logic [CNT_W-1:0]   cnt_d,     cnt_q;
    logic [2:0]         irq_d,     irq_q;
    logic [31:0]        irq_cnt_d, irq_cnt_q;

    logic [31:0] rnd;
    logic [31:0] intvl_mask;
    logic [31:0] load_full;
    logic [2:0]  sel;
    logic        src_any;
    logic        ack_hit;
    logic [31:0] irq_cnt_inc;

    lfsr32 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (SEED),
        .en    (1'b1),
        .q     (rnd)
    );

    // Interval load value and helper terms shared by the state logic
    always_comb begin
        intvl_mask  = (32'd1 << cfg_intvl_i) - 32'd1;
        load_full   = ((rnd & intvl_mask) + 32'd1) * 32'(MIN_WAIT);
        sel         = sel_src(rnd[1:0], src_mask_i);
        src_any     = (src_mask_i != 3'b000);
        ack_hit     = ((intr_ack_i & irq_q) != 3'b000);
        irq_cnt_inc = (irq_cnt_q == 32'hFFFF_FFFF) ? irq_cnt_q : irq_cnt_q + 32'd1;
    end

    // Scheduler next-state: IDLE arms the wait counter, WAIT counts down, ASSERT holds until ack
    // NOTE: every output gets a default first so no path can infer a latch
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        irq_d     = irq_q;
        irq_cnt_d = irq_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (intr_en_i && cfg_intvl_i != 4'd0 && src_any) begin
                    state_d = ST_WAIT;
                    cnt_d   = load_full[CNT_W-1:0];
                end
            end
            ST_WAIT: begin
                if (!intr_en_i || !src_any) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d   = ST_ASSERT;
                    cnt_d     = '0;
                    irq_d     = sel;
                    irq_cnt_d = irq_cnt_inc;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ASSERT: begin
                if (ack_hit) begin
                    if (rnd[31] || !intr_en_i || !src_any) begin
                        state_d = ST_IDLE;
                        irq_d   = 3'b000;
                    end else begin
                        irq_d     = sel;
                        irq_cnt_d = irq_cnt_inc;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                irq_d   = 3'b000;
            end
        endcase
    end

    // Scheduler state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            irq_q     <= 3'b000;
            irq_cnt_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            irq_q     <= irq_d;
            irq_cnt_q <= irq_cnt_d;
        end
    end

    // The global enable masks the held irq without a register stage
    assign irq_o     = irq_q & {3{intr_en_i}};
    assign busy_o    = (state_q != ST_IDLE);
    assign irq_cnt_o = irq_cnt_q;

endmodule
